mac_tx_serializer: RTL and testbench
====================================

# mac_tx_serializer

Egress-side counterpart of the MAC RX ingress path: accepts a whole packet header held in a flat byte buffer, plus its length and a drop decision from the action stage, and serializes it onto the MAC TX byte stream with valid/ready/last framing. It pads short frames to the Ethernet minimum and enforces an inter-frame gap. It sits between the egress rewrite/action stage and the MAC TX interface.

## Interface
- HEADER_BYTES, 192, capacity of pkt_flat in bytes
- LEN_W, 9, width of pkt_len
- MIN_FRAME, 60, minimum bytes on the wire per frame (pad target, excludes FCS)
- IFG_CYCLES, 12, idle cycles enforced after each frame's last byte (0 allowed)
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pkt_valid  in  1  packet descriptor valid
- pkt_ready  out  1  serializer can accept a descriptor
- pkt_flat  in  8*HEADER_BYTES  packet bytes; byte i = pkt_flat[8*i +: 8], byte 0 sent first
- pkt_len  in  LEN_W  packet length in bytes
- pkt_drop  in  1  discard this packet (action decision)
- mac_tx_valid  out  1  byte valid
- mac_tx_data  out  8  byte
- mac_tx_last  out  1  final byte of frame
- mac_tx_ready  in  1  MAC accepts byte
- tx_pkt_count  out  32  frames completed, wraps
- drop_count  out  16  packets discarded, saturates at 0xFFFF

## Operation
- States: IDLE, SEND, PAD, IFG. pkt_ready = (state == IDLE), combinational.
- Accept: pkt_valid && pkt_ready at a rising edge; pkt_flat and effective length captured into registers.
- Effective length L = min(pkt_len, HEADER_BYTES).
- pkt_drop = 1 or L = 0: descriptor consumed, drop_count += 1 (saturating), remain IDLE; no bytes emitted.
- Otherwise IDLE -> SEND, byte index = 0. Wire length W = max(L, MIN_FRAME).
- SEND: mac_tx_data = captured byte[index]; index advances on each mac_tx_valid && mac_tx_ready. After byte L-1 is taken: to PAD if L < MIN_FRAME, else frame ends.
- PAD: mac_tx_data = 0x00; continue until byte W-1 is taken.
- mac_tx_last = 1 exactly on byte W-1 (in SEND or PAD).
- Frame end (handshake on last byte): tx_pkt_count += 1 (mod 2^32); go to IFG with counter = IFG_CYCLES-1, or directly to IDLE if IFG_CYCLES = 0.
- IFG: mac_tx_valid = 0; counter decrements each cycle; -> IDLE on the edge where counter is 0.
- Stream rule: once mac_tx_valid rises, valid, data and last hold stable until mac_tx_ready; valid never drops mid-frame; no bubbles inserted by the serializer.
- Index counter width: clog2(max(HEADER_BYTES, MIN_FRAME)) + 1 bits; no wrap within a frame.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, mac_tx_valid = 0, mac_tx_data = 0, mac_tx_last = 0, tx_pkt_count = 0, drop_count = 0, pkt_ready = 1.
- Reset mid-frame: frame aborted immediately, with no last byte; counters cleared; no resume after release.
- Accept at edge N: byte 0 presented with mac_tx_valid = 1 in cycle N+1.
- With mac_tx_ready held 1: one byte per cycle; last byte in cycle N+W; pkt_ready returns IFG_CYCLES cycles after the last-byte edge. Back-to-back period = W + IFG_CYCLES + 1 cycles.
- Drop: accepted at edge N; drop_count visible cycle N+1; pkt_ready stays 1, so a drop costs one cycle per descriptor.
- mac_tx_ready low in any state: no state change in SEND/PAD; IFG still counts down (the gap is time, not handshakes).

## Test plan
- L = 64, bytes 0x00..0x3F, ready = 1 -> 64 bytes in order, last on 0x3F, tx_pkt_count = 1, pkt_ready back 12 cycles after the last byte.
- L = 14 -> 14 data bytes then 46 bytes of 0x00, last on byte 59; frame spans exactly 60 valid cycles.
- pkt_len = 300 (> 192) -> exactly 192 bytes sent, last on byte 191, no padding.
- pkt_drop = 1 on 3 descriptors, then pkt_len = 0 on 1 -> no mac_tx_valid, drop_count = 4; preload near saturation -> holds 0xFFFF.
- Random mac_tx_ready pattern on a 100-byte frame -> data/last stable while stalled, sequence intact, IFG still 12 cycles from the last handshake.
- rst_n low at byte 30 of a 64-byte frame -> mac_tx_valid 0 immediately, counters 0; next descriptor sent from byte 0.

Source files
------------

// File: rtl/mac_tx_serializer.sv
// Serializes a captured packet header onto the MAC TX byte stream, padding
// short frames to the minimum wire length and holding an inter-frame gap.
module mac_tx_serializer #(
   parameter int HEADER_BYTES = 192,
   parameter int LEN_W        = 9,
   parameter int MIN_FRAME    = 60,
   parameter int IFG_CYCLES   = 12
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      pkt_valid,
   output logic                      pkt_ready,
   input  logic [8*HEADER_BYTES-1:0] pkt_flat,
   input  logic [LEN_W-1:0]          pkt_len,
   input  logic                      pkt_drop,
   output logic                      mac_tx_valid,
   output logic [7:0]                mac_tx_data,
   output logic                      mac_tx_last,
   input  logic                      mac_tx_ready,
   output logic [31:0]               tx_pkt_count,
   output logic [15:0]               drop_count,
   output logic [1:0]                dbg_state
);

   localparam int MAX_BYTES = (HEADER_BYTES > MIN_FRAME) ? HEADER_BYTES : MIN_FRAME;
   localparam int IDX_W     = $clog2(MAX_BYTES) + 1;
   localparam int IFG_W     = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
   localparam logic [IFG_W-1:0] IFG_LOAD = (IFG_CYCLES > 0) ? IFG_W'(IFG_CYCLES - 1) : '0;
   localparam logic [IDX_W-1:0] MIN_LEN  = IDX_W'(MIN_FRAME);
   localparam logic [IDX_W-1:0] HDR_LEN  = IDX_W'(HEADER_BYTES);
   localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_PAD, ST_IFG} state_t;

   state_t                    state_q, state_d;
   logic [8*HEADER_BYTES-1:0] buf_q, buf_d;
   logic [IDX_W-1:0]          len_q, len_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [IFG_W-1:0]          ifg_q, ifg_d;
   logic [31:0]               tx_cnt_q, tx_cnt_d;
   logic [15:0]               drop_cnt_q, drop_cnt_d;

   logic [IDX_W-1:0] eff_len;
   logic [IDX_W-1:0] wire_len;
   logic [IDX_W-1:0] last_idx;
   logic [7:0]       byte_sel;
   logic             tx_hs;

   // Stream handshake: a byte transfers on any rising edge where mac_tx_valid
   // and mac_tx_ready are both 1. Valid/data/last are decoded from registered
   // state only, so they cannot change while the MAC stalls.
   assign pkt_ready    = (state_q == ST_IDLE);
   assign mac_tx_valid = (state_q == ST_SEND) || (state_q == ST_PAD);
   assign wire_len     = (len_q < MIN_LEN) ? MIN_LEN : len_q;
   assign last_idx     = wire_len - ONE;
   assign mac_tx_last  = mac_tx_valid && (idx_q == last_idx);
   assign mac_tx_data  = (state_q == ST_SEND) ? byte_sel : 8'h00;
   assign tx_hs        = mac_tx_valid && mac_tx_ready;
   assign eff_len      = (32'(pkt_len) > 32'(HEADER_BYTES)) ? HDR_LEN : IDX_W'(pkt_len);
   assign tx_pkt_count = tx_cnt_q;
   assign drop_count   = drop_cnt_q;
   assign dbg_state    = state_q;

   always_comb begin
      byte_sel = 8'h00;
      for (int i = 0; i < HEADER_BYTES; i++) begin
         if (idx_q == IDX_W'(i)) byte_sel = buf_q[8*i +: 8];
      end
   end

   always_comb begin
      state_d    = state_q;
      buf_d      = buf_q;
      len_d      = len_q;
      idx_d      = idx_q;
      ifg_d      = ifg_q;
      tx_cnt_d   = tx_cnt_q;
      drop_cnt_d = drop_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (pkt_valid) begin
               if (pkt_drop || (eff_len == '0)) begin
                  if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
               end else begin
                  buf_d   = pkt_flat;
                  len_d   = eff_len;
                  idx_d   = '0;
                  state_d = ST_SEND;
               end
            end
         end
         ST_SEND, ST_PAD: begin
            if (tx_hs) begin
               if (mac_tx_last) begin
                  tx_cnt_d = tx_cnt_q + 32'd1;
                  ifg_d    = IFG_LOAD;
                  state_d  = (IFG_CYCLES == 0) ? ST_IDLE : ST_IFG;
               end else begin
                  idx_d = idx_q + ONE;
                  // Only reachable for short frames; long frames end on this byte.
                  if ((state_q == ST_SEND) && (idx_q == len_q - ONE)) state_d = ST_PAD;
               end
            end
         end
         ST_IFG: begin
            if (ifg_q == '0) state_d = ST_IDLE;
            else             ifg_d   = ifg_q - IFG_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         buf_q      <= '0;
         len_q      <= '0;
         idx_q      <= '0;
         ifg_q      <= '0;
         tx_cnt_q   <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         buf_q      <= buf_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         ifg_q      <= ifg_d;
         tx_cnt_q   <= tx_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

endmodule

// File: tb/tb_mac_tx_serializer.sv
// Directed bench for mac_tx_serializer: framing, padding, truncation, drops,
// stall stability, inter-frame gap and mid-frame reset.
module tb_mac_tx_serializer;

   localparam int HB  = 192;
   localparam int LW  = 9;
   localparam int MF  = 60;
   localparam int IFG = 12;

   logic          clk;
   logic          rst_n;
   logic          pkt_valid;
   logic          pkt_ready;
   logic [8*HB-1:0] pkt_flat;
   logic [LW-1:0] pkt_len;
   logic          pkt_drop;
   logic          mac_tx_valid;
   logic [7:0]    mac_tx_data;
   logic          mac_tx_last;
   logic          mac_tx_ready;
   logic [31:0]   tx_pkt_count;
   logic [15:0]   drop_count;
   logic [1:0]    dbg_state;

   mac_tx_serializer #(
      .HEADER_BYTES(HB), .LEN_W(LW), .MIN_FRAME(MF), .IFG_CYCLES(IFG)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_flat(pkt_flat),
      .pkt_len(pkt_len), .pkt_drop(pkt_drop),
      .mac_tx_valid(mac_tx_valid), .mac_tx_data(mac_tx_data),
      .mac_tx_last(mac_tx_last), .mac_tx_ready(mac_tx_ready),
      .tx_pkt_count(tx_pkt_count), .drop_count(drop_count), .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // scoreboard: {last, data} per expected byte
   logic [8:0] exp_q[$];
   int         valid_cycles = 0;
   int         hs_count = 0;
   logic       stall_q = 1'b0;
   logic [7:0] hold_data;
   logic       hold_last;
   logic       rand_rdy = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            check("hold_valid", {31'b0, mac_tx_valid}, 32'd1);
            check("hold_data", {24'b0, mac_tx_data}, {24'b0, hold_data});
            check("hold_last", {31'b0, mac_tx_last}, {31'b0, hold_last});
         end
         if (mac_tx_valid) valid_cycles++;
         if (mac_tx_valid && mac_tx_ready) begin
            hs_count++;
            if (exp_q.size() == 0) check("queue_depth", 32'(exp_q.size()), 32'd1);
            else check("byte", {23'b0, mac_tx_last, mac_tx_data}, {23'b0, exp_q.pop_front()});
         end
         stall_q   = mac_tx_valid && !mac_tx_ready;
         hold_data = mac_tx_data;
         hold_last = mac_tx_last;
      end
   end

   always @(posedge clk) begin
      #1;
      if (rand_rdy) mac_tx_ready = 1'($urandom_range(0, 1));
   end

   // driver tasks
   task automatic push_frame(input logic [8*HB-1:0] flat, input int len);
      int l, w;
      logic [7:0] d;
      l = (len > HB) ? HB : len;
      w = (l < MF) ? MF : l;
      for (int i = 0; i < w; i++) begin
         d = (i < l) ? flat[8*i +: 8] : 8'h00;
         exp_q.push_back({(i == w - 1), d});
      end
   endtask

   task automatic send_desc(input logic [8*HB-1:0] flat, input int len, input logic drop);
      bit ok = 0;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (pkt_ready) begin ok = 1; break; end
      end
      if (!ok) check("ready_timeout", {31'b0, pkt_ready}, 32'd1);
      pkt_valid = 1'b1;
      pkt_flat  = flat;
      pkt_len   = len[LW-1:0];
      pkt_drop  = drop;
      @(posedge clk);
      #1;
      pkt_valid = 1'b0;
      pkt_drop  = 1'b0;
   endtask

   task automatic wait_frame(output int gap, output int gap_valid);
      bit done = 0;
      gap = -1;
      gap_valid = 0;
      for (int t = 0; t < 3000; t++) begin
         @(negedge clk); #1;
         if (exp_q.size() == 0) begin done = 1; break; end
      end
      if (!done) check("frame_timeout", 32'(exp_q.size()), 32'd0);
      for (int k = 1; k < 100; k++) begin
         @(negedge clk); #1;
         if (pkt_ready) begin gap = k; break; end
         if (mac_tx_valid) gap_valid++;
      end
   endtask

   logic [8*HB-1:0] flat;
   int gap, gap_valid;

   initial begin
      rst_n = 1'b1; pkt_valid = 1'b0; pkt_flat = '0; pkt_len = '0;
      pkt_drop = 1'b0; mac_tx_ready = 1'b1;
      #3 rst_n = 1'b0;
      #1;
      check("rst_ready", {31'b0, pkt_ready}, 32'd1);
      check("rst_valid", {31'b0, mac_tx_valid}, 32'd0);
      check("rst_data", {24'b0, mac_tx_data}, 32'd0);
      check("rst_last", {31'b0, mac_tx_last}, 32'd0);
      check("rst_txcnt", tx_pkt_count, 32'd0);
      check("rst_dropcnt", {16'b0, drop_count}, 32'd0);
      check("rst_state", {30'b0, dbg_state}, 32'd0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;

      // 64-byte frame, bytes 0x00..0x3F
      flat = '0;
      for (int i = 0; i < 64; i++) flat[8*i +: 8] = 8'(i);
      push_frame(flat, 64);
      send_desc(flat, 64, 1'b0);
      @(negedge clk); #1;
      check("first_valid", {31'b0, mac_tx_valid}, 32'd1);
      check("busy_ready", {31'b0, pkt_ready}, 32'd0);
      wait_frame(gap, gap_valid);
      check("gap64", 32'(gap), 32'(IFG + 1));
      check("gap64_valid", 32'(gap_valid), 32'd0);
      check("txcnt1", tx_pkt_count, 32'd1);

      // 14-byte frame padded to 60
      flat = '0;
      for (int i = 0; i < 14; i++) flat[8*i +: 8] = 8'hA0 + 8'(i);
      for (int i = 14; i < HB; i++) flat[8*i +: 8] = 8'hEE;
      push_frame(flat, 14);
      valid_cycles = 0;
      send_desc(flat, 14, 1'b0);
      wait_frame(gap, gap_valid);
      check("pad_valid_cycles", 32'(valid_cycles), 32'd60);
      check("txcnt2", tx_pkt_count, 32'd2);

      // pkt_len 300 truncated to 192
      for (int i = 0; i < HB; i++) flat[8*i +: 8] = 8'(i) ^ 8'h5A;
      push_frame(flat, 300);
      valid_cycles = 0;
      send_desc(flat, 300, 1'b0);
      wait_frame(gap, gap_valid);
      check("trunc_valid_cycles", 32'(valid_cycles), 32'd192);
      check("txcnt3", tx_pkt_count, 32'd3);

      // drops: three by decision, one by zero length
      valid_cycles = 0;
      send_desc(flat, 64, 1'b1);
      check("drop_visible", {16'b0, drop_count}, 32'd1);
      check("drop_ready", {31'b0, pkt_ready}, 32'd1);
      send_desc(flat, 64, 1'b1);
      send_desc(flat, 20, 1'b1);
      send_desc(flat, 0, 1'b0);
      repeat (3) @(negedge clk);
      check("drop_no_valid", 32'(valid_cycles), 32'd0);
      check("drop_cnt4", {16'b0, drop_count}, 32'd4);
      check("drop_txcnt", tx_pkt_count, 32'd3);

      // 100-byte frame under random backpressure
      for (int i = 0; i < HB; i++) flat[8*i +: 8] = 8'hC3 - 8'(i);
      push_frame(flat, 100);
      rand_rdy = 1'b1;
      send_desc(flat, 100, 1'b0);
      wait_frame(gap, gap_valid);
      check("gap_stall", 32'(gap), 32'(IFG + 1));
      check("gap_stall_valid", 32'(gap_valid), 32'd0);
      check("txcnt4", tx_pkt_count, 32'd4);
      rand_rdy = 1'b0;
      @(posedge clk); #1 mac_tx_ready = 1'b1;

      // reset mid-frame
      for (int i = 0; i < 64; i++) flat[8*i +: 8] = 8'h10 + 8'(i);
      push_frame(flat, 64);
      hs_count = 0;
      send_desc(flat, 64, 1'b0);
      for (int t = 0; t < 200; t++) begin
         @(negedge clk); #1;
         if (hs_count >= 30) break;
      end
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {31'b0, mac_tx_valid}, 32'd0);
      check("mid_rst_last", {31'b0, mac_tx_last}, 32'd0);
      check("mid_rst_txcnt", tx_pkt_count, 32'd0);
      check("mid_rst_dropcnt", {16'b0, drop_count}, 32'd0);
      check("mid_rst_ready", {31'b0, pkt_ready}, 32'd1);
      exp_q.delete();
      @(negedge clk);
      #2 rst_n = 1'b1;
      valid_cycles = 0;
      repeat (3) @(negedge clk);
      #1 check("no_resume", 32'(valid_cycles), 32'd0);
      for (int i = 0; i < 64; i++) flat[8*i +: 8] = 8'h80 + 8'(i);
      push_frame(flat, 64);
      send_desc(flat, 64, 1'b0);
      wait_frame(gap, gap_valid);
      check("post_rst_txcnt", tx_pkt_count, 32'd1);

      // drop counter saturation
      @(negedge clk);
      pkt_valid = 1'b1; pkt_drop = 1'b1; pkt_len = 9'd10;
      repeat (65534) @(posedge clk);
      #1 check("drop_fffe", {16'b0, drop_count}, 32'h0000FFFE);
      repeat (3) @(posedge clk);
      #1 pkt_valid = 1'b0; pkt_drop = 1'b0;
      check("drop_sat", {16'b0, drop_count}, 32'h0000FFFF);
      check("sat_txcnt", tx_pkt_count, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
